stream_mux_rr: RTL and testbench
================================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning number of input channels (legal 1..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning data width per channel in bits (legal 1..64).
REQ-003 The block SHALL have parameter ARB_MODE, default 1, meaning 0 = fixed priority (channel 0 highest), 1 = round-robin.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, N_CH bits, meaning per-channel valid.
REQ-007 The block SHALL have port in_data, input, N_CH*WIDTH bits, meaning channel i data at bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port in_last, input, N_CH bits, meaning per-channel end-of-packet marker.
REQ-009 The block SHALL have port in_ready, output, N_CH bits, meaning per-channel accept.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning output register holds a beat.
REQ-011 The block SHALL have port out_data, output, WIDTH bits, meaning registered selected data.
REQ-012 The block SHALL have port out_last, output, 1 bit, meaning registered selected last.
REQ-013 The block SHALL have port out_sel, output, max(1,$clog2(N_CH)) bits, meaning source channel of the current beat.
REQ-014 The block SHALL have port out_ready, input, 1 bit, meaning downstream accept.

Function
REQ-015 A beat SHALL transfer on any port only when valid and ready are both high at a rising clk edge.
REQ-016 The output register SHALL load when load = (!out_valid || out_ready), giving 1-cycle latency and full throughput.
REQ-017 in_ready SHALL be one-hot or zero, with in_ready[i] = grant[i] && load, and it SHALL NOT depend on in_valid[i] of any other channel in LOCKED state.
REQ-018 FSM IDLE: grant SHALL go to the arbiter winner among asserted in_valid.
REQ-019 In IDLE, accepting a beat with in_last=0 SHALL move the FSM to LOCKED on that channel.
REQ-020 FSM LOCKED: grant SHALL go only to the locked channel, with no interleaving even if the locked in_valid drops (bubble; others wait).
REQ-021 In LOCKED, accepting a beat with in_last=1 SHALL return the FSM to IDLE.
REQ-022 A single-beat packet (in_last=1 in IDLE) SHALL keep the FSM in IDLE.
REQ-023 Round-robin mode: the priority pointer SHALL move to (granted+1) mod N_CH after each packet-ending accept (in_last=1), wrapping N_CH-1 -> 0.
REQ-024 Fixed mode: the pointer SHALL stay 0.
REQ-025 When load is high and no channel is granted, out_valid SHALL go 0 on the next edge.
REQ-026 When out_valid=1 and out_ready=0, out_data, out_last and out_sel SHALL hold stable and all in_ready SHALL be 0.
REQ-027 When N_CH=1, the block SHALL degenerate to a 1-deep register slice with out_sel=0.

Reset
REQ-028 On rst_n low, asynchronously: out_valid=0, out_data=0, out_last=0, out_sel=0, FSM=IDLE, pointer=0, all in_ready=0.
REQ-029 A reset mid-packet SHALL discard the lock and the held beat, with no partial-packet recovery.
REQ-030 The first grant after reset release SHALL favour channel 0.

Structure
REQ-031 Package stream_mux_pkg SHALL hold the FSM state enum (IDLE, LOCKED) and the N_CH/WIDTH legal-range constants.
REQ-032 Sub-module rr_arbiter (N_CH, request vector + pointer in, one-hot grant out, combinational) SHALL be instantiated once.
REQ-033 The datapath mux SHALL be an indexed part-select on the granted index, not a case on N_CH.

Verification (N_CH=4, WIDTH=8, ARB_MODE=1)
REQ-034 Bench SHALL cover: reset, then all in_valid=0 -> out_valid=0, in_ready=0000 for 5 cycles.
REQ-035 Bench SHALL cover: ch2 sends 8'hA5, last=1, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_sel=2.
REQ-036 Bench SHALL cover: all 4 channels valid, single-beat packets, out_ready=1 -> out_sel sequence 0,1,2,3,0, one beat per cycle.
REQ-037 Bench SHALL cover: ch1 3-beat packet (11,12,13; last on 13) while ch0/ch3 valid -> out_data 11,12,13 contiguous, then ch3 granted.
REQ-038 Bench SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, in_ready=0000; on release the next beat follows without loss.
REQ-039 Bench SHALL cover: rst_n pulse mid-packet on ch1 -> out_valid=0 immediately, then the ch0 request is granted first after release.
REQ-040 Bench SHALL self-check with !== comparisons, report FAIL with expected/actual, and end on first failure.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and legal parameter ranges for the round-robin stream mux.
package stream_mux_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  localparam int N_CH_MIN  = 1;
  localparam int N_CH_MAX  = 16;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int PW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [N_CH-1:0] gnt_o
);
  logic found;
  int   idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/stream_mux_rr.sv
// N-channel packet-aware stream mux: arbitrates per packet, then locks onto the
// winning channel until its last beat, feeding a 1-deep output register slice.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH     = 4,
  parameter  int WIDTH    = 8,
  parameter  int ARB_MODE = 1,
  localparam int SW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [SW-1:0]         out_sel,
  input  logic                  out_ready
);
  state_e            state_q;
  logic [SW-1:0]     lock_q, ptr_q, ptr_d, gnt_idx;
  logic [N_CH-1:0]   arb_gnt, grant;
  logic              load, xfer, sel_last;
  logic [WIDTH-1:0]  sel_data;
  logic              out_valid_q, out_last_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [SW-1:0]     out_sel_q;

  rr_arbiter #(.N_CH(N_CH), .PW(SW)) u_arb (
    .req_i (in_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  // While locked the grant ignores every in_valid, so a stalled owner leaves a bubble.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    if (state_q == LOCKED) grant[lock_q] = 1'b1;
    else                   grant = arb_gnt;
    for (int i = 0; i < N_CH; i++)
      if (grant[i]) gnt_idx = SW'(i);
  end

  assign load     = !out_valid_q || out_ready;
  assign in_ready = (rst_n && load) ? grant : '0;
  assign xfer     = |(in_valid & in_ready);
  assign sel_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_last = in_last[gnt_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (ARB_MODE != 0 && xfer && sel_last)
      ptr_d = (gnt_idx == SW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_q      <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (load) begin
        out_valid_q <= xfer;
        if (xfer) begin
          out_data_q <= sel_data;
          out_last_q <= sel_last;
          out_sel_q  <= gnt_idx;
        end
      end
      if (xfer) begin
        unique case (state_q)
          IDLE:   if (!sel_last) begin
                    state_q <= LOCKED;
                    lock_q  <= gnt_idx;
                  end
          LOCKED: if (sel_last) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (4 channels, 8-bit, round-robin).
module tb_stream_mux_rr;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_last, out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;

  typedef struct packed {logic [1:0] sel; logic last; logic [7:0] data;} beat_t;
  typedef struct {logic [3:0] v; logic [3:0] ir; logic ov; logic [1:0] sel;} vec_t;

  beat_t sb_q[$];
  vec_t  tbl[7];
  int    n_cmp = 0;
  int    n_err = 0;

  stream_mux_rr #(.N_CH(4), .WIDTH(8), .ARB_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      n_err++;
      summary_and_finish();
    end
  endtask

  task automatic push(input logic [1:0] sel, input logic last, input logic [7:0] data);
    beat_t b;
    b.sel = sel; b.last = last; b.data = data;
    sb_q.push_back(b);
  endtask

  task automatic setd(input int ch, input logic [7:0] d);
    in_data[ch*8 +: 8] = d;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic [1:0] oh2i(input logic [3:0] v);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // Every downstream handshake must match the oldest expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("sb_unexpected_beat", {out_sel, out_last, out_data}, 32'hFFFF);
      else begin
        e = sb_q.pop_front();
        chk("sb_beat", {21'd0, out_sel, out_last, out_data}, {21'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    summary_and_finish();
  end

  initial begin
    rst_n = 1'b0; in_valid = 4'hF; in_data = '0; in_last = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_last",  out_last, 0);
    chk("rst_out_sel",   out_sel, 0);
    chk("rst_in_ready",  in_ready, 0);
    in_valid = 4'h0;
    @(posedge clk); #1 rst_n = 1'b1;

    // idle: nothing requested
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_in_ready", in_ready, 0);
      next_cyc();
    end

    // all channels, single-beat packets: rotate 0,1,2,3,0
    in_data = 32'h3332_3130; in_last = 4'hF;
    tbl[0] = '{4'hF, 4'b0001, 1'b0, 2'd0};
    tbl[1] = '{4'hF, 4'b0010, 1'b1, 2'd0};
    tbl[2] = '{4'hF, 4'b0100, 1'b1, 2'd1};
    tbl[3] = '{4'hF, 4'b1000, 1'b1, 2'd2};
    tbl[4] = '{4'hF, 4'b0001, 1'b1, 2'd3};
    tbl[5] = '{4'h0, 4'b0000, 1'b1, 2'd0};
    tbl[6] = '{4'h0, 4'b0000, 1'b0, 2'd0};
    for (int r = 0; r < 7; r++) begin
      in_valid = tbl[r].v;
      if (tbl[r].ir != 4'b0) push(oh2i(tbl[r].ir), 1'b1, 8'h30 + 8'(oh2i(tbl[r].ir)));
      @(negedge clk);
      chk("rr_in_ready", in_ready, tbl[r].ir);
      chk("rr_out_valid", out_valid, tbl[r].ov);
      if (tbl[r].ov) chk("rr_out_sel", out_sel, tbl[r].sel);
      next_cyc();
    end

    // ch1 3-beat packet while ch0/ch3 wait, then ch3 wins
    setd(0, 8'hC0); setd(3, 8'hD3); setd(1, 8'h11); in_last = 4'b1001; in_valid = 4'b1011;
    push(2'd1, 1'b0, 8'h11);
    @(negedge clk); chk("pkt_ir_b0", in_ready, 4'b0010); next_cyc();
    setd(1, 8'h12); push(2'd1, 1'b0, 8'h12);
    @(negedge clk); chk("pkt_ir_b1", in_ready, 4'b0010); chk("pkt_data_11", out_data, 8'h11); next_cyc();
    setd(1, 8'h13); in_last[1] = 1'b1; push(2'd1, 1'b1, 8'h13);
    @(negedge clk); chk("pkt_ir_b2", in_ready, 4'b0010); chk("pkt_data_12", out_data, 8'h12); next_cyc();
    in_valid = 4'b1001; push(2'd3, 1'b1, 8'hD3);
    @(negedge clk); chk("pkt_ir_ch3", in_ready, 4'b1000); chk("pkt_data_13", out_data, 8'h13);
    chk("pkt_valid_13", out_valid, 1); next_cyc();
    in_valid = 4'b0001; push(2'd0, 1'b1, 8'hC0);
    @(negedge clk); chk("pkt_ir_ch0", in_ready, 4'b0001); chk("pkt_sel_3", out_sel, 3); next_cyc();
    in_valid = 4'b0000;
    @(negedge clk); chk("pkt_sel_0", out_sel, 0); next_cyc();

    // ch2 single beat, then backpressure for 3 cycles
    in_valid = 4'b0100; setd(2, 8'hA5); in_last = 4'b0100; push(2'd2, 1'b1, 8'hA5);
    @(negedge clk); chk("one_pre_valid", out_valid, 0); chk("one_ir", in_ready, 4'b0100); next_cyc();
    setd(2, 8'h5A); out_ready = 1'b0; push(2'd2, 1'b1, 8'h5A);
    @(negedge clk);
    chk("one_valid", out_valid, 1); chk("one_data", out_data, 8'hA5);
    chk("one_sel", out_sel, 2); chk("one_last", out_last, 1); chk("bp_ir0", in_ready, 0);
    next_cyc();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); chk("bp_data_hold", out_data, 8'hA5); chk("bp_ir", in_ready, 0); next_cyc();
    end
    out_ready = 1'b1;
    @(negedge clk); chk("bp_rel_ir", in_ready, 4'b0100); chk("bp_rel_data", out_data, 8'hA5); next_cyc();
    in_valid = 4'b0000;
    @(negedge clk); chk("bp_next_valid", out_valid, 1); chk("bp_next_data", out_data, 8'h5A); next_cyc();
    @(negedge clk); chk("bp_drained", out_valid, 0); next_cyc();

    // ch1 packet with a bubble, then reset mid-packet
    in_valid = 4'b0010; setd(1, 8'h21); in_last = 4'b0000; push(2'd1, 1'b0, 8'h21);
    @(negedge clk); chk("rp_ir_b0", in_ready, 4'b0010); next_cyc();
    in_valid = 4'b0001; setd(0, 8'hC0); in_last = 4'b0001;
    @(negedge clk); chk("rp_lock_ir", in_ready, 4'b0010); chk("rp_data_21", out_data, 8'h21); next_cyc();
    in_valid = 4'b0011; setd(1, 8'h22); push(2'd1, 1'b0, 8'h22);
    @(negedge clk); chk("rp_bubble", out_valid, 0); chk("rp_lock_ir2", in_ready, 4'b0010); next_cyc();
    rst_n = 1'b0; #1;
    chk("rp_rst_valid", out_valid, 0); chk("rp_rst_ir", in_ready, 0);
    sb_q.delete();
    setd(1, 8'h23); in_last = 4'b0011;
    @(posedge clk); #1 rst_n = 1'b1;
    push(2'd0, 1'b1, 8'hC0);
    @(negedge clk); chk("rp_first_ch0", in_ready, 4'b0001); next_cyc();
    in_valid = 4'b0010; push(2'd1, 1'b1, 8'h23);
    @(negedge clk); chk("rp_ir_ch1", in_ready, 4'b0010); chk("rp_sel0", out_sel, 0);
    chk("rp_data_c0", out_data, 8'hC0); next_cyc();
    in_valid = 4'b0000;
    @(negedge clk); chk("rp_data_23", out_data, 8'h23); chk("rp_sel1", out_sel, 1); next_cyc();
    @(negedge clk); chk("rp_end_valid", out_valid, 0);
    chk("sb_leftover", sb_q.size(), 0);
    summary_and_finish();
  end
endmodule
